// File: rtl/pwm_carrier_sched.sv
// Carrier run-time scheduler: shadowed config with safe-point commit,
// PWM start re-arm and graceful stop with mask-point timeout.
module pwm_carrier_sched #(
  parameter int W        = 16,
  parameter bit STOP_MIN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_period,
  input  logic [W-1:0] cfg_init,
  input  logic [1:0]   cfg_count_mode,
  input  logic [1:0]   cfg_mask_mode,
  input  logic         cmd_start,
  input  logic         cmd_stop,
  input  logic         mask_event_i,
  output logic [W-1:0] period_o,
  output logic [W-1:0] init_carr_o,
  output logic [1:0]   count_mode_o,
  output logic [1:0]   mask_mode_o,
  output logic         pwm_onoff_o,
  output logic [1:0]   state_o,
  output logic         upd_done,
  output logic         fault
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    RUN       = 2'd2,
    STOP_WAIT = 2'd3
  } state_t;

  localparam logic [1:0] NO_MASK = 2'd0;
  localparam logic       PWM_ON  = 1'b1;
  localparam logic       PWM_OFF = 1'b0;

  state_t         state;
  state_t         state_nxt;
  logic           pending;
  logic [W-1:0]   sh_period;
  logic [W-1:0]   sh_init;
  logic [1:0]     sh_count_mode;
  logic [1:0]     sh_mask_mode;
  logic [W+1:0]   tmo;
  logic [W+1:0]   limit;
  logic           tmo_hit;
  logic           start;
  logic           commit;
  logic           fault_set;
  logic           fault_clr;

  assign cfg_ready = ~pending;
  assign state_o   = state;
  assign start     = cmd_start & ~cmd_stop;

  // Wide enough that 2*(2^W-1)+2 does not wrap.
  assign limit   = ({2'b00, period_o} << 1) + (W+2)'(2);
  // STOP_WAIT lasts exactly limit cycles before timing out.
  assign tmo_hit = (tmo + (W+2)'(1)) == limit;

  assign commit = pending &
                  ((state != RUN) | mask_event_i |
                   (mask_mode_o == NO_MASK));

  always_comb begin
    state_nxt = state;
    fault_set = 1'b0;
    fault_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (period_o != '0) begin
            state_nxt = ARM;
            fault_clr = 1'b1;
          end else begin
            fault_set = 1'b1;
          end
        end
      end
      ARM: begin
        state_nxt = cmd_stop ? IDLE : RUN;
      end
      RUN: begin
        if (cmd_stop)
          state_nxt = STOP_MIN ? STOP_WAIT : IDLE;
      end
      STOP_WAIT: begin
        if (mask_event_i) begin
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          fault_set = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pwm_onoff_o <= PWM_OFF;
      fault       <= 1'b0;
      tmo         <= '0;
    end else begin
      state       <= state_nxt;
      pwm_onoff_o <= ((state_nxt == RUN) | (state_nxt == STOP_WAIT))
                     ? PWM_ON : PWM_OFF;
      if (fault_set)
        fault <= 1'b1;
      else if (fault_clr)
        fault <= 1'b0;
      if (state == STOP_WAIT)
        tmo <= tmo + (W+2)'(1);
      else
        tmo <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending       <= 1'b0;
      upd_done      <= 1'b0;
      sh_period     <= '0;
      sh_init       <= '0;
      sh_count_mode <= '0;
      sh_mask_mode  <= '0;
      period_o      <= '0;
      init_carr_o   <= '0;
      count_mode_o  <= '0;
      mask_mode_o   <= '0;
    end else begin
      upd_done <= commit;
      if (commit) begin
        pending      <= 1'b0;
        period_o     <= sh_period;
        init_carr_o  <= sh_init;
        count_mode_o <= sh_count_mode;
        mask_mode_o  <= sh_mask_mode;
      end
      if (cfg_valid & ~pending) begin
        pending       <= 1'b1;
        sh_period     <= cfg_period;
        sh_init       <= cfg_init;
        sh_count_mode <= cfg_count_mode;
        sh_mask_mode  <= cfg_mask_mode;
      end
    end
  end

endmodule
